bcd_bin_seq: RTL and testbench

//  Sequential multi-digit BCD-to-binary converter; inverse of the 4-bit binary->BCD digit path.

---
 rtl/bcd_bin_seq.sv | 89 ++++++++
 tb/tb_bcd_bin_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bcd_bin_seq.sv
// bcd_bin_seq: sequential multi-digit BCD-to-binary converter, Horner accumulation MSD first, one digit per clock
module bcd_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCD_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [BIN_W-1:0]      BIN_OUT,
  output logic                  ERR
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic {IDLE, CONV} state_t;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] sh_q, sh_d;
  logic [BIN_W-1:0]    acc_q, acc_d, acc_nx, bin_q, bin_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d, err_nx;
  logic                busy_q, busy_d, done_q, done_d, erro_q, erro_d;
  logic [3:0]          dig;
  logic [BIN_W+3:0]    prod;
  always_comb begin
    dig     = sh_q[4*DIGITS-1 -: 4];
    prod    = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{BIN_W{1'b0}}, dig};
    acc_nx  = prod[BIN_W-1:0];
    err_nx  = err_q | (dig > 4'd9);
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    erro_d  = erro_q;
    if (state_q == IDLE) begin
      if (START) begin
        sh_d    = BCD_IN;
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = CONV;
      end
    end else begin
      acc_d = acc_nx;
      err_d = err_nx;
      sh_d  = sh_q << 4;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DIGITS - 1)) begin
        bin_d   = err_nx ? '0 : acc_nx;
        erro_d  = err_nx;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      erro_q  <= erro_d;
    end
  end
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BIN_OUT = bin_q;
  assign ERR     = erro_q;
endmodule

// File: tb/tb_bcd_bin_seq.sv
// tb_bcd_bin_seq: randomized + directed bench for bcd_bin_seq against a decimal-arithmetic reference model
module tb_bcd_bin_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  logic              CLK = 1'b0;
  logic              RSTN = 1'b1;
  logic              START = 1'b0;
  logic [11:0]       BCD_IN = '0;
  logic              BUSY, DONE, ERR;
  logic [BIN_W-1:0]  BIN_OUT;
  int total = 0, passed = 0;
  bcd_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .BCD_IN(BCD_IN),
    .BUSY(BUSY), .DONE(DONE), .BIN_OUT(BIN_OUT), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // Decimal value of a BCD word, or -1 when any digit is A..F
  function automatic int ref_val(input logic [11:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction
  // Model: a conversion accepted at an edge completes DIGITS edges later
  int rem = 0, m_bin = 0, p_bin = 0;
  bit m_done = 0, m_err = 0, p_err = 0;
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rem = 0; m_done = 0; m_bin = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done = 1; m_bin = p_bin; m_err = p_err;
        end
      end else if (START) begin
        rem = DIGITS;
        p_err = ref_val(BCD_IN) < 0;
        p_bin = p_err ? 0 : ref_val(BCD_IN);
      end
    end
  end
  always @(negedge CLK) begin
    chk("busy", int'(BUSY), int'(rem > 0));
    chk("done", int'(DONE), int'(m_done));
    chk("bin_out", int'(BIN_OUT), m_bin);
    chk("err", int'(ERR), int'(m_err));
  end
  task automatic step();
    @(posedge CLK); #2;
  endtask
  task automatic wait_done(input string name, input int ebin, input bit eerr);
    int nb = 0;
    while (BUSY && nb < 20) begin nb++; step(); end
    chk({name, "_busy_len"}, nb, DIGITS);
    chk({name, "_done"}, int'(DONE), 1);
    chk({name, "_bin"}, int'(BIN_OUT), ebin);
    chk({name, "_err"}, int'(ERR), int'(eerr));
  endtask
  task automatic conv(input string name, input logic [11:0] bcd, input int ebin, input bit eerr);
    step(); START = 1; BCD_IN = bcd;
    step(); START = 0; BCD_IN = 12'(~bcd);
    wait_done(name, ebin, eerr);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    #1 RSTN = 0;
    repeat (2) step();
    RSTN = 1;
    repeat (8) step();
    chk("idle_busy", int'(BUSY), 0);
    chk("idle_done", int'(DONE), 0);
    chk("idle_bin", int'(BIN_OUT), 0);
    chk("idle_err", int'(ERR), 0);
    conv("t999", 12'h999, 999, 0);
    step();
    chk("done_one_cycle", int'(DONE), 0);
    chk("bin_held", int'(BIN_OUT), 999);
    conv("t000", 12'h000, 0, 0);
    conv("t407", 12'h407, 407, 0);
    conv("t1a5", 12'h1A5, 0, 1);
    conv("t042", 12'h042, 42, 0);
    step(); START = 1; BCD_IN = 12'h123;
    step(); BCD_IN = 12'h321;
    wait_done("t123", 123, 0);
    step();
    wait_done("t321", 321, 0);
    START = 0;
    repeat (2) step();
    START = 1; BCD_IN = 12'h555;
    step(); START = 0;
    step();
    chk("abort_busy_before", int'(BUSY), 1);
    RSTN = 0; #1;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_bin", int'(BIN_OUT), 0);
    repeat (4) begin step(); chk("abort_no_done", int'(DONE), 0); end
    RSTN = 1;
    conv("t555", 12'h555, 555, 0);
    for (int c = 0; c < 3000; c++) begin
      step();
      RSTN = ($urandom_range(0, 299) != 0);
      START = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < DIGITS; i++) BCD_IN[4*i +: 4] = 4'($urandom_range(0, 11));
    end
    RSTN = 1; START = 0;
    repeat (6) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
